// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, widths, colours and the alignment-stage record for the LCD timing driver.
package lcd_timing_pkg;

    localparam int RGB_W = 24;
    localparam int POS_W = 12;

    localparam int H_SYNC_DEF   = 1;
    localparam int H_BACK_DEF   = 46;
    localparam int H_DISP_DEF   = 800;
    localparam int H_FRONT_DEF  = 210;
    localparam int V_SYNC_DEF   = 1;
    localparam int V_BACK_DEF   = 23;
    localparam int V_DISP_DEF   = 480;
    localparam int V_FRONT_DEF  = 22;
    localparam int DATA_LAT_DEF = 1;

    localparam logic [RGB_W-1:0] BLACK = 24'h000000;
    localparam logic [RGB_W-1:0] WHITE = 24'hFFFFFF;

    typedef enum logic [1:0] {
        SEG_SYNC,
        SEG_BACK,
        SEG_DISP,
        SEG_FRONT
    } seg_t;

    // Per-pixel flags carried alongside the pixel until its data arrives.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic de;
        logic fs;
        logic border;
    } align_t;

    localparam align_t ALIGN_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0, fs: 1'b0, border: 1'b0};

    function automatic seg_t seg_of(input logic [POS_W-1:0] cnt, input int sync_w,
                                    input int back_w, input int disp_w);
        int c;
        c = int'(cnt);
        if (c < sync_w)
            return SEG_SYNC;
        else if (c < sync_w + back_w)
            return SEG_BACK;
        else if (c < sync_w + back_w + disp_w)
            return SEG_DISP;
        else
            return SEG_FRONT;
    endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// Horizontal/vertical raster counters with raw (unaligned) sync, active flag and x/y decode.
module lcd_sync_counter
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_DISP  = H_DISP_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_DISP  = V_DISP_DEF,
    parameter int V_FRONT = V_FRONT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             raw_hs_n,
    output logic             raw_vs_n,
    output logic             raw_de,
    output logic [POS_W-1:0] raw_x,
    output logic [POS_W-1:0] raw_y
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_OFF   = H_SYNC + H_BACK;
    localparam int V_OFF   = V_SYNC + V_BACK;

    logic [POS_W-1:0] h_cnt_reg;
    logic [POS_W-1:0] v_cnt_reg;
    logic             h_last;
    logic             v_last;
    seg_t             h_seg;
    seg_t             v_seg;

    assign h_last = (h_cnt_reg == POS_W'(H_TOTAL - 1));
    assign v_last = (v_cnt_reg == POS_W'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_last) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        h_seg    = seg_of(h_cnt_reg, H_SYNC, H_BACK, H_DISP);
        v_seg    = seg_of(v_cnt_reg, V_SYNC, V_BACK, V_DISP);
        raw_hs_n = (h_seg != SEG_SYNC);
        raw_vs_n = (v_seg != SEG_SYNC);
        raw_de   = (h_seg == SEG_DISP) && (v_seg == SEG_DISP);
        raw_x    = '0;
        raw_y    = '0;
        if (raw_de) begin
            raw_x = h_cnt_reg - POS_W'(H_OFF);
            raw_y = v_cnt_reg - POS_W'(V_OFF);
        end
    end

endmodule

// File: rtl/lcd_timing_driver.sv
// Raster timing master: pixel requests, latency-matched sync/DE pipeline and RGB capture.
// Optional feature macro LCD_BORDER_EN forces a white one-pixel frame around the active area.
module lcd_timing_driver
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_DISP   = H_DISP_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_DISP   = V_DISP_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int DATA_LAT = DATA_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RGB_W-1:0] lcd_data_in,
    output logic             lcd_request,
    output logic [POS_W-1:0] lcd_xpos,
    output logic [POS_W-1:0] lcd_ypos,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output logic [RGB_W-1:0] lcd_rgb,
    output logic             frame_start
);

    if (H_SYNC + H_BACK + H_DISP + H_FRONT > (1 << POS_W)) begin : g_h_total_err
        $error("lcd_timing_driver: horizontal total exceeds position width");
    end
    if (V_SYNC + V_BACK + V_DISP + V_FRONT > (1 << POS_W)) begin : g_v_total_err
        $error("lcd_timing_driver: vertical total exceeds position width");
    end
    if (DATA_LAT < 1 || DATA_LAT > 4 || H_BACK < DATA_LAT) begin : g_lat_err
        $error("lcd_timing_driver: DATA_LAT out of range");
    end

    logic             raw_hs_n;
    logic             raw_vs_n;
    logic             raw_de;
    logic [POS_W-1:0] raw_x;
    logic [POS_W-1:0] raw_y;

    lcd_sync_counter #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_DISP  (H_DISP),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_DISP  (V_DISP),
        .V_FRONT (V_FRONT)
    ) u_sync_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_hs_n (raw_hs_n),
        .raw_vs_n (raw_vs_n),
        .raw_de   (raw_de),
        .raw_x    (raw_x),
        .raw_y    (raw_y)
    );

    logic             req_reg;
    logic [POS_W-1:0] xpos_reg;
    logic [POS_W-1:0] ypos_reg;
    align_t           req_stage_reg;
    align_t           req_stage_next;

    always_comb begin
        req_stage_next        = ALIGN_IDLE;
        req_stage_next.hs_n   = raw_hs_n;
        req_stage_next.vs_n   = raw_vs_n;
        req_stage_next.de     = raw_de;
        req_stage_next.fs     = raw_de && (raw_x == '0) && (raw_y == '0);
`ifdef LCD_BORDER_EN
        req_stage_next.border = raw_de && ((raw_x == '0) || (raw_x == POS_W'(H_DISP - 1)) ||
                                           (raw_y == '0) || (raw_y == POS_W'(V_DISP - 1)));
`else
        req_stage_next.border = 1'b0;
`endif
    end

    // The request stage carries the sync flags too, so every panel signal sees the same delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_reg       <= 1'b0;
            xpos_reg      <= '0;
            ypos_reg      <= '0;
            req_stage_reg <= ALIGN_IDLE;
        end else begin
            req_reg       <= raw_de;
            xpos_reg      <= raw_x;
            ypos_reg      <= raw_y;
            req_stage_reg <= req_stage_next;
        end
    end

    for (genvar gi = 0; gi <= DATA_LAT; gi++) begin : g_align
        align_t stage_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    stage_reg <= ALIGN_IDLE;
                else
                    stage_reg <= req_stage_reg;
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    stage_reg <= ALIGN_IDLE;
                else
                    stage_reg <= g_align[gi-1].stage_reg;
            end
        end
    end

    // load_stage describes the pixel whose data is on lcd_data_in this cycle.
    align_t           load_stage;
    align_t           out_stage;
    logic [RGB_W-1:0] rgb_reg;
    logic [RGB_W-1:0] rgb_next;

    assign load_stage = g_align[DATA_LAT-1].stage_reg;
    assign out_stage  = g_align[DATA_LAT].stage_reg;

    always_comb begin
        rgb_next = BLACK;
        if (load_stage.de)
            rgb_next = load_stage.border ? WHITE : lcd_data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rgb_reg <= BLACK;
        else
            rgb_reg <= rgb_next;
    end

    assign lcd_request = req_reg;
    assign lcd_xpos    = xpos_reg;
    assign lcd_ypos    = ypos_reg;
    assign lcd_hs      = out_stage.hs_n;
    assign lcd_vs      = out_stage.vs_n;
    assign lcd_de      = out_stage.de;
    assign frame_start = out_stage.fs;
    assign lcd_rgb     = rgb_reg;

endmodule
